// File: rtl/tama_ui_pkg.sv
// Shared definitions for the Tamagotchi UI blocks: indicator state encoding,
// default blink timing and a helper that sizes the phase timer.
package tama_ui_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } ui_state_t;

    localparam int unsigned CLK_HZ            = 50_000_000;
    localparam int unsigned BLINK_ON_DEFAULT  = CLK_HZ / 2;
    localparam int unsigned BLINK_OFF_DEFAULT = CLK_HZ / 2;

    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/ui_cycle_timer.sv
// Loadable down-counter: after a load of value V, expire is high for exactly
// one cycle, V+1 cycles later (the cycle in which the count reaches zero).
module ui_cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;
    logic         running;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= load_val;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) running <= 1'b0;
            else             count   <= count - 1'b1;
        end
    end

    // A reload in the expiry cycle takes priority, so phases chain back to back.
    assign expire = running && (count == '0);

endmodule

// File: rtl/indicator_pulser.sv
// Turns a one-cycle trig into blinks x (ON_CYCLES high, OFF_CYCLES low) on ind_out.
// Define INDICATOR_PULSER_PENDING_EN to queue one request that arrives while busy.
module indicator_pulser
    import tama_ui_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = BLINK_ON_DEFAULT,
    parameter int unsigned OFF_CYCLES = BLINK_OFF_DEFAULT,
    parameter int unsigned CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] blinks,
    output logic             ind_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned TW = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

    ui_state_t        state, state_next;
    logic [CNT_W-1:0] remaining, remaining_next, remaining_dec;
    logic             done_next;
    logic             timer_load;
    logic [TW-1:0]    timer_val;
    logic             expire;
    logic             start_req;

    assign start_req     = trig && (blinks != '0);
    assign remaining_dec = remaining - CNT_W'(1);

`ifdef INDICATOR_PULSER_PENDING_EN
    logic             pend_valid, pend_valid_next;
    logic [CNT_W-1:0] pend_cnt, pend_cnt_next;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        done_next      = 1'b0;
        timer_load     = 1'b0;
        timer_val      = ON_LOAD;
`ifdef INDICATOR_PULSER_PENDING_EN
        pend_valid_next = pend_valid;
        pend_cnt_next   = pend_cnt;
        if (state != IDLE && start_req) begin
            pend_valid_next = 1'b1;
            pend_cnt_next   = blinks;
        end
`endif
        unique case (state)
            IDLE: begin
                if (start_req) begin
                    state_next     = ON;
                    remaining_next = blinks;
                    timer_load     = 1'b1;
                    timer_val      = ON_LOAD;
                end
            end
            ON: begin
                if (expire) begin
                    state_next = OFF;
                    timer_load = 1'b1;
                    timer_val  = OFF_LOAD;
                end
            end
            OFF: begin
                if (expire) begin
                    remaining_next = remaining_dec;
                    if (remaining_dec != '0) begin
                        state_next = ON;
                        timer_load = 1'b1;
                        timer_val  = ON_LOAD;
                    end else begin
                        done_next  = 1'b1;
                        state_next = IDLE;
`ifdef INDICATOR_PULSER_PENDING_EN
                        // The newest request (this cycle's trig, else the stored one) starts now.
                        if (start_req || pend_valid) begin
                            state_next      = ON;
                            remaining_next  = start_req ? blinks : pend_cnt;
                            timer_load      = 1'b1;
                            timer_val       = ON_LOAD;
                            pend_valid_next = 1'b0;
                        end
`endif
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and clears every register, because a reset
    // mid-sequence must drop the indicator on the very next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            ind_out   <= 1'b0;
            done      <= 1'b0;
`ifdef INDICATOR_PULSER_PENDING_EN
            pend_valid <= 1'b0;
            pend_cnt   <= '0;
`endif
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            ind_out   <= (state_next == ON);
            done      <= done_next;
`ifdef INDICATOR_PULSER_PENDING_EN
            pend_valid <= pend_valid_next;
            pend_cnt   <= pend_cnt_next;
`endif
        end
    end

    assign busy = (state != IDLE);

    ui_cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (expire)
    );

endmodule

// File: tb/tb_indicator_pulser.sv
// Self-checking bench for indicator_pulser (ON=4, OFF=3, CNT_W=3): directed table,
// corner-case sequences and random traffic against a schedule-based model.
module tb_indicator_pulser;

    localparam int ON_C  = 4;
    localparam int OFF_C = 3;
    localparam int P     = ON_C + OFF_C;
`ifdef INDICATOR_PULSER_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [2:0] blinks;
    logic       ind_out, busy, done;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Model: a sequence is "active" from start for n*P cycles; outputs follow by arithmetic.
    bit m_active = 0;
    int m_start  = 0;
    int m_n      = 0;
    bit m_pv     = 0;
    int m_pn     = 0;
    bit m_ind = 0, m_busy = 0, m_done = 0;

    typedef struct {
        logic       trig;
        logic [2:0] blinks;
        logic       ind;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tv[16];

    indicator_pulser #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig),
        .blinks  (blinks),
        .ind_out (ind_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d: got %b want %b", name, cyc, act, exp);
        end
    endtask

    task automatic model_update(input logic t, input logic [2:0] b, input logic r);
        bit nd = 0;
        bit req = t && (b != 0);
        if (!r) begin
            m_active = 0;
            m_pv     = 0;
        end else if (m_active && cyc == m_start + m_n * P - 1) begin
            nd = 1;
            if (PEND && req) begin
                m_start = cyc + 1; m_n = int'(b); m_pv = 0;
            end else if (PEND && m_pv) begin
                m_start = cyc + 1; m_n = m_pn; m_pv = 0;
            end else begin
                m_active = 0;
            end
        end else if (m_active) begin
            if (PEND && req) begin
                m_pv = 1; m_pn = int'(b);
            end
        end else if (req) begin
            m_active = 1; m_start = cyc + 1; m_n = int'(b);
        end
        m_done = nd;
        m_busy = m_active;
        m_ind  = m_active && (((cyc + 1 - m_start) % P) < ON_C);
    endtask

    // Drive one cycle of inputs, advance past the edge, leave outputs ready to sample.
    task automatic step(input logic t, input logic [2:0] b, input logic r);
        trig   = t;
        blinks = b;
        rst    = r;
        model_update(t, b, r);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ind"},  ind_out, m_ind);
        check({tag, ".busy"}, busy,    m_busy);
        check({tag, ".done"}, done,    m_done);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 3'd0, 1'b1);
            check_model(tag);
        end
    endtask

    initial begin
        int first_on, done_k, pulses, dones;
        logic prev_ind;
        bit busy_dropped;

        // Entry k: inputs of cycle N+k, expected outputs of cycle N+k+1.
        tv[0]  = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b0};
        tv[1]  = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tv[10] = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        tv[11] = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tv[12] = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tv[13] = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        tv[14] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        tv[15] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

        trig = 1'b0; blinks = '0; rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'd5, 1'b0);
            check_model("reset");
        end
        idle(2, "post_reset");

        for (int k = 0; k < 16; k++) begin
            step(tv[k].trig, tv[k].blinks, 1'b1);
            check($sformatf("tbl%0d.ind", k),  ind_out, tv[k].ind);
            check($sformatf("tbl%0d.busy", k), busy,    tv[k].busy);
            check($sformatf("tbl%0d.done", k), done,    tv[k].done);
        end

        step(1'b1, 3'd0, 1'b1);
        check_model("zero_blinks");
        idle(20, "zero_blinks");

        // Reset at N+6 of a 3-blink run, fresh trig at N+10.
        step(1'b1, 3'd3, 1'b1);
        check_model("midrst");
        idle(5, "midrst");
        step(1'b0, 3'd0, 1'b0);
        check("midrst.ind_drop",  ind_out, 1'b0);
        check("midrst.busy_drop", busy,    1'b0);
        check_model("midrst");
        idle(3, "midrst");
        step(1'b1, 3'd3, 1'b1);
        check_model("restart");
        idle(25, "restart");

        // 1-blink run with a second request at N+3.
        step(1'b1, 3'd1, 1'b1);
        check_model("busy_trig");
        for (int k = 1; k < 40; k++) begin
            step(k == 3, (k == 3) ? 3'd5 : 3'd0, 1'b1);
            check_model("busy_trig");
            if (k == 7) check("busy_trig.done_n8", done, 1'b1);
        end

`ifdef INDICATOR_PULSER_PENDING_EN
        busy_dropped = 0;
        dones = 0;
        step(1'b1, 3'd1, 1'b1);
        check_model("pend");
        for (int k = 1; k < 35; k++) begin
            step(k == 2 || k == 4, (k == 2) ? 3'd2 : ((k == 4) ? 3'd3 : 3'd0), 1'b1);
            check_model("pend");
            if (k <= 27 && !busy) busy_dropped = 1;
            if (k == 7)  check("pend.done1", done, 1'b1);
            if (k == 28) check("pend.done2", done, 1'b1);
        end
        check("pend.busy_held", busy_dropped, 1'b0);
`endif

        // Seven blinks: pulse count and done offset from first ON cycle.
        pulses = 0; first_on = -1; done_k = -1; prev_ind = 1'b0;
        step(1'b1, 3'd7, 1'b1);
        for (int k = 0; k < 60; k++) begin
            if (k > 0) step(1'b0, 3'd0, 1'b1);
            check_model("seven");
            if (ind_out && !prev_ind) pulses++;
            if (ind_out && first_on < 0) first_on = k;
            if (done && done_k < 0) done_k = k;
            prev_ind = ind_out;
        end
        check("seven.pulses_eq_7", pulses == 7, 1'b1);
        check("seven.done_at_49", (done_k - first_on) == 49, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)),
                 !($urandom_range(0, 299) == 0));
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
